// File: rtl/eth_mac_tx_frame_arbiter.sv
// Purpose : frame-granular round-robin arbiter sharing one AXI-stream TX path among PORTS sources.
// Latency : 1 cycle from source beat acceptance to m_axis; 1 selection cycle between frames.
// Backpr. : the granted source sees ready only when the output register is free; a stalled source is cut off by a watchdog.
//
// Ports:
//   logic_clk, logic_rst            clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last,user}  per-port source streams (port i data at [i*DATA_WIDTH +: DATA_WIDTH])
//   m_axis_t{data,valid,ready,last,user}  registered output towards the MAC TX FIFO
//   port_enable                     per-port grant eligibility mask
//   grant_valid, grant_index        current / last owner of the output
//   stat_frame_done, stat_stall_abort   single-cycle event pulses
module eth_mac_tx_frame_arbiter #(
  parameter int PORTS         = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int STALL_TIMEOUT = 256,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                          logic_clk,
  input  logic                          logic_rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS-1:0]              s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic [PORTS-1:0]              port_enable,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_index,
  output logic                          stat_frame_done,
  output logic                          stat_stall_abort
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_ABORT,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]         last_grant;
  logic [TIMEOUT_WIDTH-1:0] stall_cnt;

  logic [DATA_WIDTH-1:0] src_dat [PORTS];
  logic                  slot_free;
  logic                  cur_vld, cur_last, cur_user;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic [PORTS-1:0]      req;
  logic [IDX_W-1:0]      sel, cand;
  logic                  sel_found;
  logic                  accept, frame_end, drain_end, fire_abort, stall_hit;

  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign src_dat[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign cur_vld   = s_axis_tvalid[grant_index];
  assign cur_last  = s_axis_tlast[grant_index];
  assign cur_user  = s_axis_tuser[grant_index];
  assign cur_dat   = src_dat[grant_index];
  assign req       = s_axis_tvalid & port_enable;

  // Round-robin pick: first requester after last_grant, wrapping PORTS-1 -> 0.
  always_comb begin
    sel       = '0;
    cand      = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % PORTS);
      if (!sel_found && req[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    accept        = 1'b0;
    frame_end     = 1'b0;
    drain_end     = 1'b0;
    fire_abort    = 1'b0;
    stall_hit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        s_axis_tready[grant_index] = slot_free;
        accept    = cur_vld && slot_free;
        frame_end = accept && cur_last;
        // The counter only advances while the source itself is idle, so output
        // backpressure can never trigger an abort. tlast needs tvalid, so a
        // completing beat and a timeout are mutually exclusive.
        stall_hit = !cur_vld && (stall_cnt == TIMEOUT_WIDTH'(STALL_TIMEOUT - 1));
        if (frame_end)      state_nxt = S_IDLE;
        else if (stall_hit) state_nxt = S_ABORT;
      end
      S_ABORT: begin
        if (slot_free) begin
          fire_abort = 1'b1;
          state_nxt  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Swallow the rest of the aborted frame so the source can resynchronise.
        s_axis_tready[grant_index] = 1'b1;
        drain_end = cur_vld && cur_last;
        if (drain_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      m_axis_tdata     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser     <= 1'b0;
      grant_valid      <= 1'b0;
      grant_index      <= '0;
      last_grant       <= IDX_W'(PORTS - 1);
      stall_cnt        <= '0;
      stat_frame_done  <= 1'b0;
      stat_stall_abort <= 1'b0;
    end else begin
      stat_frame_done  <= frame_end;
      stat_stall_abort <= fire_abort;

      if (accept) begin
        m_axis_tdata  <= cur_dat;
        m_axis_tlast  <= cur_last;
        m_axis_tuser  <= cur_user;
        m_axis_tvalid <= 1'b1;
      end else if (fire_abort) begin
        // Synthetic terminator: flagged bad so the MAC drops the truncated frame.
        m_axis_tdata  <= '0;
        m_axis_tlast  <= 1'b1;
        m_axis_tuser  <= 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (state == S_IDLE && sel_found) begin
        grant_index <= sel;
        grant_valid <= 1'b1;
      end else if (frame_end || drain_end) begin
        last_grant  <= grant_index;
        grant_valid <= 1'b0;
      end

      if (state == S_ACTIVE && !cur_vld && !stall_hit)
        stall_cnt <= stall_cnt + 1'b1;
      else
        stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_eth_mac_tx_frame_arbiter.sv
// Purpose : randomized and directed checking of eth_mac_tx_frame_arbiter against a frame-level model.
// Latency : model predicts beat order only; timing checks are explicit where they matter.
// Backpr. : m_axis_tready is driven fixed or random; scoreboard pops on every accepted output beat.
module tb_eth_mac_tx_frame_arbiter;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int STALL_GAP = 300;  // longer than the watchdog timeout of 256

  logic                 logic_clk;
  logic                 logic_rst;
  logic [PORTS*DW-1:0]  s_axis_tdata;
  logic [PORTS-1:0]     s_axis_tvalid;
  logic [PORTS-1:0]     s_axis_tready;
  logic [PORTS-1:0]     s_axis_tlast;
  logic [PORTS-1:0]     s_axis_tuser;
  logic [DW-1:0]        m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic                 m_axis_tuser;
  logic [PORTS-1:0]     port_enable;
  logic                 grant_valid;
  logic [1:0]           grant_index;
  logic                 stat_frame_done;
  logic                 stat_stall_abort;

  eth_mac_tx_frame_arbiter #(
    .PORTS(PORTS), .DATA_WIDTH(DW), .STALL_TIMEOUT(256), .TIMEOUT_WIDTH(16)
  ) dut (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .port_enable(port_enable), .grant_valid(grant_valid), .grant_index(grant_index),
    .stat_frame_done(stat_frame_done), .stat_stall_abort(stat_stall_abort)
  );

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
    logic          user;
    int            gap;   // idle cycles the source inserts before this beat
  } beat_t;

  typedef struct {
    int start;
    int len;
    int stall_at;         // 0: normal frame; k: source stalls after k beats
  } fdesc_t;

  beat_t  pq [PORTS][$];  // per-port source beats still to send
  int     gapcnt [PORTS];
  fdesc_t mq [PORTS][$];  // per-port frames the model has not yet scheduled
  beat_t  store [$];
  beat_t  exp_q [$];
  int     acc_cyc [$];

  int m_last;
  int exp_done  = 0;
  int exp_abort = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  logic rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;

  initial begin
    logic_clk = 1'b0;
    forever #5 logic_clk = ~logic_clk;
  end

  always @(posedge logic_clk) cyc <= cyc + 1;

  // Source driver: sample handshakes mid-cycle, update drive just after the edge.
  initial begin
    logic [PORTS-1:0]    acc;
    logic [PORTS*DW-1:0] d;
    logic [PORTS-1:0]    v, l, u;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    for (int p = 0; p < PORTS; p++) gapcnt[p] = 0;
    forever begin
      @(negedge logic_clk);
      acc = s_axis_tvalid & s_axis_tready & {PORTS{!logic_rst}};
      @(posedge logic_clk);
      #1;
      d = '0; v = '0; l = '0; u = '0;
      for (int p = 0; p < PORTS; p++) begin
        if (acc[p] && pq[p].size() > 0) begin
          void'(pq[p].pop_front());
          gapcnt[p] = (pq[p].size() > 0) ? pq[p][0].gap : 0;
        end else if (gapcnt[p] > 0) begin
          gapcnt[p]--;
        end
        if (pq[p].size() > 0 && gapcnt[p] == 0) begin
          d[p*DW +: DW] = pq[p][0].dat;
          v[p] = 1'b1;
          l[p] = pq[p][0].last;
          u[p] = pq[p][0].user;
        end
      end
      s_axis_tdata  = d;
      s_axis_tvalid = v;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
    end
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge logic_clk);
      #1;
      m_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  // Monitor / scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge logic_clk);
      if (!logic_rst) begin
        if (stat_frame_done)  done_cnt++;
        if (stat_stall_abort) abort_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
          acc_cyc.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat got dat=%h last=%b user=%b, none expected",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser);
          end else begin
            e = exp_q.pop_front();
            if (m_axis_tdata !== e.dat || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
              failures++;
              $display("FAIL beat got dat=%h last=%b user=%b expected dat=%h last=%b user=%b",
                       m_axis_tdata, m_axis_tlast, m_axis_tuser, e.dat, e.last, e.user);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge logic_clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic do_reset();
    logic_rst = 1'b1;
    for (int p = 0; p < PORTS; p++) begin
      pq[p].delete();
      mq[p].delete();
      gapcnt[p] = 0;
    end
    exp_q.delete();
    m_last = PORTS - 1;
    tick(3);
    logic_rst = 1'b0;
  endtask

  task automatic load_frame(input int p, input int len, input int base, input int stall_at, input int maxgap);
    beat_t  b;
    fdesc_t f;
    f.start = store.size();
    f.len = len;
    f.stall_at = stall_at;
    for (int i = 0; i < len; i++) begin
      b.dat  = (base < 0) ? DW'($urandom) : DW'(base + i);
      b.last = (i == len - 1);
      b.user = (base < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == 0)             b.gap = 0;
      else if (i == stall_at) b.gap = STALL_GAP;
      else                    b.gap = int'($urandom_range(0, maxgap));
      store.push_back(b);
      pq[p].push_back(b);
    end
    mq[p].push_back(f);
  endtask

  // Frame-level reference: every loaded frame requests continuously, so grants
  // follow plain round-robin over the ports that have frames and are enabled.
  task automatic plan(input logic [PORTS-1:0] mask, input int maxn);
    fdesc_t f;
    beat_t  ab;
    int     found, c, nout;
    for (int n = 0; n < maxn; n++) begin
      found = -1;
      for (int k = 1; k <= PORTS; k++) begin
        c = (m_last + k) % PORTS;
        if (found < 0 && mask[c] && mq[c].size() > 0) found = c;
      end
      if (found < 0) break;
      f = mq[found].pop_front();
      nout = (f.stall_at > 0) ? f.stall_at : f.len;
      for (int i = 0; i < nout; i++) exp_q.push_back(store[f.start + i]);
      if (f.stall_at > 0) begin
        ab.dat = '0; ab.last = 1'b1; ab.user = 1'b1; ab.gap = 0;
        exp_q.push_back(ab);
        exp_abort++;
      end else begin
        exp_done++;
      end
      m_last = found;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while (exp_q.size() > 0 && t < budget) begin
      tick(1);
      t++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    tick(4);
    check({name, "_frame_done"}, done_cnt, exp_done);
    check({name, "_stall_abort"}, abort_cnt, exp_abort);
  endtask

  task automatic wait_grant(input string name, input int idx, input int budget);
    int t = 0;
    while (!grant_valid && t < budget) begin
      tick(1);
      t++;
    end
    check(name, {grant_valid, grant_index}, {1'b1, 2'(idx)});
  endtask

  task automatic wait_ungrant(input string name, input int budget);
    int t = 0;
    while (grant_valid && t < budget) begin
      tick(1);
      t++;
    end
    check(name, grant_valid, 0);
  endtask

  initial begin
    int bad;
    int p, len, st;
    logic_rst   = 1'b1;
    port_enable = '1;
    m_last      = PORTS - 1;
    do_reset();

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("reset_idle",
            {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, s_axis_tready,
             grant_valid, grant_index, stat_frame_done, stat_stall_abort}, 64'd0);
    end

    // 2: two simultaneous 5-beat frames
    acc_cyc.delete();
    load_frame(0, 5, 'h10, 0, 0);
    load_frame(2, 5, 'h30, 0, 0);
    plan(4'hF, 10);
    wait_grant("t2_grant0", 0, 20);
    wait_ungrant("t2_ungrant0", 20);
    wait_grant("t2_grant2", 2, 20);
    wait_drain("t2", 100);
    check("t2_beats", acc_cyc.size(), 10);
    if (acc_cyc.size() == 10) begin
      check("t2_frame0_contig", acc_cyc[4] - acc_cyc[0], 4);
      check("t2_gap", acc_cyc[5] - acc_cyc[4], 2);
      check("t2_frame2_contig", acc_cyc[9] - acc_cyc[5], 4);
    end

    // 3: all ports streaming single-beat frames
    do_reset();
    acc_cyc.delete();
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < PORTS; q++) load_frame(q, 1, 'h40 + r*16 + q, 0, 0);
    plan(4'hF, 20);
    wait_drain("t3", 200);
    bad = 0;
    for (int i = 0; i + 1 < acc_cyc.size(); i++)
      if (acc_cyc[i+1] - acc_cyc[i] != 2) bad++;
    check("t3_beats", acc_cyc.size(), 12);
    check("t3_spacing_bad", bad, 0);

    // 4: stall watchdog
    do_reset();
    load_frame(1, 6, 'h50, 3, 0);
    plan(4'hF, 1);
    wait_grant("t4_grant1", 1, 20);
    load_frame(0, 2, 'h60, 0, 0);
    load_frame(2, 2, 'h70, 0, 0);
    plan(4'hF, 10);
    wait_ungrant("t4_ungrant1", 700);
    wait_grant("t4_grant2", 2, 20);
    wait_drain("t4", 200);

    // 5: long output backpressure mid-frame
    do_reset();
    acc_cyc.delete();
    load_frame(3, 8, 'h80, 0, 0);
    plan(4'hF, 1);
    bad = 0;
    while (acc_cyc.size() < 3 && bad < 50) begin
      tick(1);
      bad++;
    end
    check("t5_started", acc_cyc.size() >= 3, 1);
    rdy_fixed = 1'b0;
    tick(2);
    bad = 0;
    repeat (1000) begin
      tick(1);
      if (exp_q.size() == 0) bad++;
      else if (!(m_axis_tvalid && !m_axis_tready && m_axis_tdata == exp_q[0].dat)) bad++;
    end
    check("t5_hold_bad", bad, 0);
    check("t5_no_abort", abort_cnt, exp_abort);
    rdy_fixed = 1'b1;
    wait_drain("t5", 100);

    // 6a: disabled port is never granted
    do_reset();
    port_enable = 4'b1011;
    for (int q = 0; q < PORTS; q++) load_frame(q, 2, 'h90 + q*16, 0, 0);
    plan(4'b1011, 10);
    wait_drain("t6a", 200);
    tick(20);
    check("t6a_port2_idle", grant_valid, 0);

    // 6b: enable drop mid-frame lets the frame finish, no regrant
    do_reset();
    port_enable = 4'b1011;
    load_frame(0, 6, 'hA0, 0, 3);
    load_frame(0, 2, 'hB0, 0, 0);
    load_frame(1, 2, 'hC0, 0, 0);
    load_frame(3, 2, 'hD0, 0, 0);
    plan(4'b1011, 1);
    wait_grant("t6b_grant0", 0, 20);
    port_enable = 4'b1010;
    plan(4'b1010, 10);
    wait_drain("t6b", 300);
    tick(10);
    check("t6b_no_regrant", grant_valid, 0);

    // 7: randomized traffic with random backpressure and occasional stalls
    do_reset();
    port_enable = 4'hF;
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      p   = int'($urandom_range(0, PORTS - 1));
      len = int'($urandom_range(1, 8));
      st  = (len > 1 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      load_frame(p, len, -1, st, 4);
    end
    plan(4'hF, 100);
    wait_drain("t7", 30000);
    rdy_rand = 1'b0;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_mac_tx_frame_arbiter.md
Name: eth_mac_tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one 8-bit AXI-stream TX path (the MAC TX FIFO input) between PORTS source streams, all in the logic clock domain.
- Once a port is granted, it owns the output until its tlast beat is accepted.
- A stall watchdog terminates a frame whose source goes idle mid-frame, so the MAC never sees an unterminated frame.

Parameters:
- PORTS, 4: number of requesters, 2..16.
- DATA_WIDTH, 8: tdata width.
- STALL_TIMEOUT, 256: consecutive mid-frame cycles with granted s_tvalid low before abort; ≥2.
- TIMEOUT_WIDTH, 16: stall counter width; must hold STALL_TIMEOUT.

Ports:
- logic_clk  in  1  clock.
- logic_rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  PORTS*DATA_WIDTH  per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  PORTS  per-port valid.
- s_axis_tready  out  PORTS  per-port ready.
- s_axis_tlast  in  PORTS  per-port last.
- s_axis_tuser  in  PORTS  per-port bad-frame flag.
- m_axis_tdata  out  DATA_WIDTH  to TX FIFO.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  1  output bad-frame flag.
- port_enable  in  PORTS  per-port grant eligibility mask.
- grant_valid  out  1  a port currently owns the output.
- grant_index  out  $clog2(PORTS)  owning/last-owning port.
- stat_frame_done  out  1  1-cycle pulse when a tlast beat is accepted from a source (not on abort).
- stat_stall_abort  out  1  1-cycle pulse when the watchdog fires.

Behaviour:
- Reset (logic_rst high at a logic_clk edge), all outputs 0:
  - m_axis_tvalid/tlast/tuser/tdata = 0.
  - s_axis_tready = 0, grant_valid = 0, grant_index = 0.
  - both stat pulses = 0.
  - Internal: last_grant = PORTS-1 so port 0 has first priority; stall counter = 0; state = IDLE.
  - Reset mid-frame drops the frame silently; no abort beat is emitted.
- Output is one register stage. Output slot is free when !m_axis_tvalid | m_axis_tready.
- A source beat is accepted when s_axis_tvalid[g] & s_axis_tready[g]; it appears on m_axis on the next cycle (latency 1).
- States:
  - IDLE:
    - request vector = s_axis_tvalid & port_enable.
    - If nonzero, select the first set bit searching last_grant+1, +2, ... modulo PORTS.
    - Register the result into grant_index, set grant_valid=1, go to ACTIVE.
    - No beat is accepted in the selection cycle. All s_axis_tready=0.
  - ACTIVE:
    - s_axis_tready[g] = output slot free; all other ready bits are 0.
    - Accepted beat loads the output register: tdata, tlast, tuser copied.
    - Accepted beat with tlast: pulse stat_frame_done, last_grant<=g, grant_valid<=0, go to IDLE.
    - Deasserting port_enable[g] mid-frame has no effect until the frame ends.
    - Stall counter: resets to 0 on any cycle with s_axis_tvalid[g]=1; otherwise increments.
    - When the counter would reach STALL_TIMEOUT, go to ABORT. Stalls caused by m_axis_tready=0 never count.
  - ABORT:
    - Wait for output slot free, then emit one beat: tdata=0, tlast=1, tuser=1.
    - Pulse stat_stall_abort in that same cycle. Go to DRAIN.
  - DRAIN:
    - s_axis_tready[g]=1, beats discarded, nothing to m_axis.
    - On accepted tlast: last_grant<=g, grant_valid<=0, go to IDLE. No stat_frame_done pulse.
- Simultaneous events:
  - Tlast acceptance and timeout in the same cycle: tlast wins, no abort.
  - Back-to-back frames from the same port are allowed only if no other enabled port requests in the IDLE cycle.
- Throughput: 1 beat/cycle within a frame; exactly 1 idle cycle (IDLE selection) between frames.
- Wrap-around: the round-robin pointer wraps PORTS-1 -> 0.
- Single-beat frames (tvalid & tlast on the first beat) are legal.
- tuser passes through unmodified except on the abort beat.

Test Plan:
1. Reset release with all sources idle -> m_axis_tvalid=0, all s_axis_tready=0, grant_valid=0 for 10 cycles.
2. Ports 0 and 2 each present a 5-beat frame (0x10..0x14, 0x30..0x34) simultaneously, m_axis_tready=1:
   - Output is port-0 frame, 1 gap cycle, then port-2 frame.
   - grant_index 0 then 2; stat_frame_done pulses twice.
3. All 4 ports continuously request 1-beat frames:
   - Grant order 0,1,2,3,0,1.
   - One frame per 2 cycles.
   - No port starved.
4. Port 1 sends 3 beats, then holds tvalid low for 256 cycles (STALL_TIMEOUT=256):
   - Output shows 3 beats, then abort beat tdata=0x00 tlast=1 tuser=1.
   - stat_stall_abort pulses once.
   - Remaining port-1 beats up to tlast are discarded.
   - Next grant goes to port 2.
5. m_axis_tready held low for 1000 cycles mid-frame, source valid high:
   - No abort; the output beat is held stable.
   - Frame completes intact when tready returns.
6. port_enable=4'b1011 with port 2 requesting -> port 2 never granted.
   Clear port_enable[0] during a port-0 frame -> that frame completes fully; port 0 is not regranted.
